// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer
// Frame-scan master for the 96x64 SSD1331 PmodOLED. Walks the frame pixel by
// pixel, presents the current coordinate to the active screen renderer,
// captures the RGB565 colour it returns and shifts it MSB-first to the panel
// over a mode-0 SPI write link (2 system clocks per SPI bit). Emits a
// per-frame strobe and a wrapping frame counter for blinking screen content.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   enable       level; frames stream while high
//   x, y         registered pixel coordinate presented to the renderer
//   oled_data    RGB565 colour for the current x/y (may be combinational)
//   pixel_sample high in the cycle oled_data is captured
//   sclk, mosi   SPI clock (idles low) and data
//   cs_n         chip select, active low, held low for the whole frame
//   dc           data/command select, 1 while streaming pixel data
//   frame_begin  one-cycle pulse in the first capture cycle of a frame
//   frame_count  frames completed, wraps 255 -> 0
//   busy         high from frame start until the inter-frame gap ends

module oled_pixel_streamer #(
  parameter int WIDTH     = 96,
  parameter int HEIGHT    = 64,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [6:0]  x,
  output logic [5:0]  y,
  input  logic [15:0] oled_data,
  output logic        pixel_sample,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        dc,
  output logic        frame_begin,
  output logic [7:0]  frame_count,
  output logic        busy
);

  localparam int               GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [4:0]       bit_cnt, bit_cnt_next;
  logic [15:0]      shifter, shifter_next;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
  logic [6:0]       x_next;
  logic [5:0]       y_next;
  logic [7:0]       frame_count_next;
  logic             last_pixel;

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  // Next-state and datapath. bit_cnt is the SHIFT index k; each SPI bit spans
  // an even/odd pair of k, so the shifter advances after every odd k and the
  // next bit appears on mosi while sclk is low.
  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    shifter_next     = shifter;
    gap_cnt_next     = gap_cnt;
    x_next           = x;
    y_next           = y;
    frame_count_next = frame_count;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = LOAD;
          x_next     = 7'd0;
          y_next     = 6'd0;
        end
      end

      LOAD: begin
        shifter_next = oled_data;
        bit_cnt_next = 5'd0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        bit_cnt_next = bit_cnt + 5'd1;
        if (bit_cnt[0]) begin
          shifter_next = {shifter[14:0], 1'b0};
        end
        if (bit_cnt == 5'd31) begin
          if (last_pixel) begin
            state_next       = GAP;
            x_next           = 7'd0;
            y_next           = 6'd0;
            gap_cnt_next     = '0;
            frame_count_next = frame_count + 8'd1;
          end else begin
            state_next = LOAD;
            if (x < X_LAST) begin
              x_next = x + 7'd1;
            end else begin
              x_next = 7'd0;
              y_next = y + 6'd1;
            end
          end
        end
      end

      GAP: begin
        gap_cnt_next = gap_cnt + GAP_ONE;
        if (gap_cnt == GAP_LAST) begin
          // Coordinates are already 0 here, so a back-to-back frame needs no
          // further setup.
          state_next = enable ? LOAD : IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and pin registers. The SPI pins are registered from the next state
  // so they leave the block glitch-free and line up with the SHIFT index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 5'd0;
      shifter     <= 16'd0;
      gap_cnt     <= '0;
      x           <= 7'd0;
      y           <= 6'd0;
      frame_count <= 8'd0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= 1'b1;
      dc          <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shifter     <= shifter_next;
      gap_cnt     <= gap_cnt_next;
      x           <= x_next;
      y           <= y_next;
      frame_count <= frame_count_next;
      sclk        <= (state_next == SHIFT) && bit_cnt_next[0];
      mosi        <= (state_next == SHIFT) && shifter_next[15];
      cs_n        <= !((state_next == LOAD) || (state_next == SHIFT));
      dc          <= (state_next != IDLE);
    end
  end

  // x/y are both zero only while the first pixel of a frame is loaded.
  assign pixel_sample = (state == LOAD);
  assign frame_begin  = (state == LOAD) && (x == 7'd0) && (y == 6'd0);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// tb_oled_pixel_streamer
// Self-checking bench for oled_pixel_streamer with a 4x2 frame and a 4-cycle
// gap. A renderer model answers x/y with a per-frame colour pattern; the
// stimulus side queues the frame's expected pixel words in raster order and
// a monitor decodes the SPI stream and checks it against that queue, along
// with coordinates, strobes, frame count and pin rules.

module tb_oled_pixel_streamer;

  localparam int TW     = 4;
  localparam int TH     = 2;
  localparam int TG     = 4;
  localparam int NPIX   = TW * TH;
  localparam int PERIOD = 33 * TW * TH + TG;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] rdata;
  logic        pixel_sample, sclk, mosi, cs_n, dc, frame_begin, busy;
  logic [7:0]  frame_count;

  int tests = 0;
  int fails = 0;

  // Renderer content: mode 0 = {y,x} pattern, 1 = solid red, 2 = random table.
  int          cur_mode = 0;
  logic [15:0] lut [0:NPIX-1];
  logic [15:0] exp_q [$];

  logic cs_n_d = 1'b1, sclk_d = 1'b0, mosi_d = 1'b0;
  logic gap_entry;

  oled_pixel_streamer #(.WIDTH(TW), .HEIGHT(TH), .FRAME_GAP(TG)) dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .y(y),
    .oled_data(rdata), .pixel_sample(pixel_sample), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .dc(dc), .frame_begin(frame_begin),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (cur_mode)
      0:       rdata = {2'b00, y, 1'b0, x};
      1:       rdata = 16'hF800;
      default: rdata = lut[(int'(y) * TW + int'(x)) % NPIX];
    endcase
  end

  always @(posedge clk) begin
    cs_n_d <= cs_n;
    sclk_d <= sclk;
    mosi_d <= mosi;
  end

  assign gap_entry = busy && cs_n && !cs_n_d;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference colour of pixel (px,py) for a content mode.
  function automatic logic [15:0] refColor(input int mode, input int px, input int py);
    if (mode == 0) return 16'((py << 8) + px);
    if (mode == 1) return 16'hF800;
    return lut[py * TW + px];
  endfunction

  // Set the renderer content for the next frame and queue its words.
  task automatic applyStimulus(input int mode);
    if (mode == 2) begin
      for (int i = 0; i < NPIX; i++) lut[i] = 16'($urandom);
    end
    cur_mode = mode;
    for (int py = 0; py < TH; py++)
      for (int px = 0; px < TW; px++)
        exp_q.push_back(refColor(mode, px, py));
  endtask

  task automatic waitGap();
    bit found = 1'b0;
    for (int i = 0; i < PERIOD + 100 && !found; i++) begin
      @(negedge clk);
      if (gap_entry) found = 1'b1;
    end
    checkOutput("gap_reached", 32'(found), 32'd1);
  endtask

  task automatic waitPixel(input int px, input int py);
    bit found = 1'b0;
    for (int i = 0; i < PERIOD + 100 && !found; i++) begin
      @(negedge clk);
      if (pixel_sample && int'(x) == px && int'(y) == py) found = 1'b1;
    end
    checkOutput("pixel_reached", 32'(found), 32'd1);
  endtask

  // Monitor: decodes SPI words, tracks raster position and frame completion.
  int          pix = 0;
  int          bits = 0;
  logic [15:0] word = 16'd0;
  int          frames_done = 0;
  int          cycle = 0;
  int          last_fb = 0;
  bit          fb_chain = 1'b0;

  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      pix = 0; bits = 0; word = 16'd0; frames_done = 0; fb_chain = 1'b0;
    end else begin
      checkOutput("x_range", 32'(int'(x) <= TW - 1), 32'd1);
      checkOutput("y_range", 32'(int'(y) <= TH - 1), 32'd1);
      if (!busy) fb_chain = 1'b0;
      checkOutput("frame_begin", 32'(frame_begin), 32'(pixel_sample && pix == 0));
      if (pixel_sample) begin
        checkOutput("pixel_x", 32'(x), 32'(pix % TW));
        checkOutput("pixel_y", 32'(y), 32'(pix / TW));
        checkOutput("load_cs_n", 32'(cs_n), 32'd0);
        checkOutput("load_dc", 32'(dc), 32'd1);
        checkOutput("bits_per_word", 32'(bits), 32'd0);
        if (frame_begin) begin
          if (fb_chain) checkOutput("fb_period", 32'(cycle - last_fb), 32'(PERIOD));
          fb_chain = 1'b1;
          last_fb  = cycle;
        end
        pix++;
      end
      if (sclk && !sclk_d) begin
        checkOutput("sclk_cs_n", 32'(cs_n), 32'd0);
        checkOutput("sclk_dc", 32'(dc), 32'd1);
        checkOutput("mosi_stable", 32'(mosi), 32'(mosi_d));
        word = {word[14:0], mosi};
        bits++;
        if (bits == 16) begin
          checkOutput("word_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) checkOutput("spi_word", 32'(word), 32'(exp_q.pop_front()));
          bits = 0;
        end
      end
      if (busy && cs_n) begin
        checkOutput("gap_sclk", 32'(sclk), 32'd0);
        checkOutput("gap_mosi", 32'(mosi), 32'd0);
      end
      if (gap_entry) begin
        checkOutput("pixels_per_frame", 32'(pix), 32'(NPIX));
        checkOutput("gap_bits", 32'(bits), 32'd0);
        frames_done++;
        checkOutput("frame_count", 32'(frame_count), 32'(frames_done % 256));
        pix = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int restarts;
    bit idle_seen;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_cs_n", 32'(cs_n), 32'd1);
    checkOutput("rst_sclk", 32'(sclk), 32'd0);
    checkOutput("rst_mosi", 32'(mosi), 32'd0);
    checkOutput("rst_dc", 32'(dc), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_begin", 32'(frame_begin), 32'd0);
    checkOutput("rst_pixel_sample", 32'(pixel_sample), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);

    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_hold_busy", 32'(busy), 32'd0);

    // Five back-to-back frames with different content; enable dropped in the last.
    applyStimulus(0);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("enable_latency", 32'(frame_begin), 32'd1);
    for (int f = 1; f <= 4; f++) begin
      waitGap();
      applyStimulus(f == 1 ? 1 : 2);
    end
    waitPixel(3, 0);
    enable = 1'b0;
    idle_seen = 1'b0;
    for (int i = 0; i < PERIOD + 100 && !idle_seen; i++) begin
      @(negedge clk);
      if (!busy) idle_seen = 1'b1;
    end
    checkOutput("busy_falls", 32'(idle_seen), 32'd1);
    checkOutput("idle_cs_n", 32'(cs_n), 32'd1);
    checkOutput("idle_dc", 32'(dc), 32'd0);
    checkOutput("frames_after_drop", 32'(frame_count), 32'd5);
    restarts = 0;
    for (int i = 0; i < PERIOD + 32; i++) begin
      @(negedge clk);
      if (frame_begin || !cs_n) restarts++;
    end
    checkOutput("no_restart", 32'(restarts), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in SHIFT k=9 of pixel 5 (x=1,y=1).
    applyStimulus(2);
    enable = 1'b1;
    waitPixel(1, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_cs_n", 32'(cs_n), 32'd1);
    checkOutput("mid_rst_x", 32'(x), 32'd0);
    checkOutput("mid_rst_y", 32'(y), 32'd0);
    checkOutput("mid_rst_sclk", 32'(sclk), 32'd0);
    checkOutput("mid_rst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    applyStimulus(0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("restart_frame_begin", 32'(frame_begin), 32'd1);
    checkOutput("restart_x", 32'(x), 32'd0);
    checkOutput("restart_y", 32'(y), 32'd0);

    // 256 consecutive random frames: frame_count wraps back to 0.
    for (int f = 1; f <= 256; f++) begin
      waitGap();
      if (f < 256) applyStimulus(2);
      else enable = 1'b0;
    end
    checkOutput("wrap_count", 32'(frame_count), 32'd0);
    repeat (TG + 4) @(negedge clk);
    checkOutput("final_busy", 32'(busy), 32'd0);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
